// File: rtl/adder_share_sequencer.sv
// Round-robin shares one SLICE-bit adder between two requesters; result after NSLICE cycles.
// Inputs accepted only in IDLE (valid/ready); result held in DONE until res_ready, no accept meanwhile.
module adder8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic c;
  always_comb begin
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end
endmodule

module adder_share_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [SW-1:0]    slice_q, slice_d;
  logic             cin_q, cin_d, carry_q, carry_d, last_q, last_d;
  logic             id_q, id_d, rcarry_q, rcarry_d, vld_q, vld_d;

  logic             gnt_id, sel_sub, slice_cin, slice_cout;
  logic [SLICE-1:0] slice_a, slice_b, slice_sum;

  assign slice_a   = a_q[32'(slice_q) * SLICE +: SLICE];
  assign slice_b   = b_q[32'(slice_q) * SLICE +: SLICE];
  assign slice_cin = (slice_q == '0) ? cin_q : carry_q;

  adder8 #(.W(SLICE)) u_adder (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .cin_i (slice_cin),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  // On contention the requester not served last wins; a lone requester always wins.
  assign gnt_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign sel_sub = gnt_id ? req1_sub : req0_sub;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    slice_d    = slice_q;
    cin_d      = cin_q;
    carry_d    = carry_q;
    last_d     = last_q;
    id_d       = id_q;
    rcarry_d   = rcarry_q;
    vld_d      = vld_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = rst_n && req0_valid && !gnt_id;
        req1_ready = rst_n && req1_valid && gnt_id;
        if (req0_valid || req1_valid) begin
          a_d     = gnt_id ? req1_a : req0_a;
          b_d     = (gnt_id ? req1_b : req0_b) ^ {WIDTH{sel_sub}};
          cin_d   = sel_sub;
          id_d    = gnt_id;
          last_d  = gnt_id;
          slice_d = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[32'(slice_q) * SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        slice_d = slice_q + 1'b1;
        if (slice_q == SW'(NSLICE - 1)) begin
          rcarry_d = slice_cout;
          vld_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      slice_q  <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      rcarry_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      slice_q  <= slice_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      last_q   <= last_d;
      id_q     <= id_d;
      rcarry_q <= rcarry_d;
      vld_q    <= vld_d;
    end
  end

  assign res_valid = vld_q;
  assign res_id    = id_q;
  assign res_sum   = sum_q;
  assign res_carry = rcarry_q;
endmodule

// File: tb/tb_adder_share_sequencer.sv
// Bench for adder_share_sequencer: directed ops feed a scoreboard queue, a monitor pops on each result handshake.
module tb_adder_share_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_id, res_carry;
  logic [31:0] res_sum;

  typedef struct {
    logic        id;
    logic [31:0] sum;
    logic        carry;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  adder_share_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_sub  (req0_sub),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_sub  (req1_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_carry (res_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: results are compared in the order they were issued.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("res_id", res_id, mon_e.id);
        check("res_sum", res_sum, mon_e.sum);
        check("res_carry", res_carry, mon_e.carry);
      end
    end
  end

  task automatic issue(input bit p, input logic [31:0] a, input logic [31:0] b, input bit sub,
                       input bit push, input logic [31:0] es, input bit ec);
    bit done = 0;
    @(negedge clk);
    if (p) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (p ? req1_ready : req0_ready) begin
        if (push) sb.push_back('{p, es, ec});
        @(posedge clk);
        #1;
        // Operands are scrambled after accept; the result must not depend on them.
        if (p) begin
          req1_valid = 0; req1_a = ~a; req1_b = ~b; req1_sub = ~sub;
        end else begin
          req0_valid = 0; req0_a = ~a; req0_b = ~b; req0_sub = ~sub;
        end
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      check("issue_timeout", 1, 0);
      req0_valid = 0;
      req1_valid = 0;
    end
  endtask

  task automatic contend(input string tag,
                         input logic [31:0] a0, input logic [31:0] b0, input bit s0, input logic [31:0] e0, input bit c0,
                         input logic [31:0] a1, input logic [31:0] b1, input bit s1, input logic [31:0] e1, input bit c1);
    int order[$];
    bit busy = 0;
    bit acc0, acc1;
    int cyc = 0;
    @(negedge clk);
    req0_valid = 1; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = 1; req1_a = a1; req1_b = b1; req1_sub = s1;
    while ((req0_valid || req1_valid) && cyc < 100) begin
      #1;
      if (busy) begin
        check({tag, "_req1_rdy_busy"}, req1_ready, 0);
        busy = 0;
      end
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0 && acc1) check({tag, "_dual_grant"}, 1, 0);
      if (acc0) begin sb.push_back('{1'b0, e0, c0}); order.push_back(0); end
      if (acc1) begin sb.push_back('{1'b1, e1, c1}); order.push_back(1); end
      @(posedge clk);
      #1;
      if (acc0) begin req0_valid = 0; busy = req1_valid; end
      if (acc1) req1_valid = 0;
      @(negedge clk);
      cyc++;
    end
    req0_valid = 0;
    req1_valid = 0;
    if (order.size() != 2) begin
      check({tag, "_accepts"}, order.size(), 2);
    end else begin
      check({tag, "_first_id"}, order[0], 0);
      check({tag, "_second_id"}, order[1], 1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    #3;
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] hs;
    logic        hid, hc;
    int          lat;
    bit          saw;

    rst_n = 0; res_ready = 1;
    req0_valid = 1; req0_a = 0; req0_b = 0; req0_sub = 0;
    req1_valid = 1; req1_a = 0; req1_b = 0; req1_sub = 0;
    #3;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_carry", res_carry, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Contention straight out of reset: req0 first, then alternation brings req0 first again.
    contend("rr1", 32'h10, 32'h20, 0, 32'h30, 0, 32'h80000000, 32'h80000000, 0, 32'h0, 1);
    drain();
    contend("rr2", 32'd100, 32'd1, 1, 32'h63, 1, 32'h12345678, 32'h11111111, 0, 32'h23456789, 0);
    drain();

    issue(0, 32'h30E0E0E0, 32'h22555555, 0, 1, 32'h53363635, 0);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (res_valid) lat = k;
    end
    check("latency", lat, 4);
    drain();

    issue(1, 32'hFFFFFFFF, 32'h00000001, 0, 1, 32'h00000000, 1);
    drain();
    issue(0, 32'd5, 32'd7, 1, 1, 32'hFFFFFFFE, 0);
    drain();

    // Backpressure: result held across stalled cycles, a waiting requester sees no ready.
    res_ready = 0;
    issue(0, 32'hDEADBEEF, 32'h01010101, 0, 1, 32'hDFAEBFF0, 0);
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      #1;
      saw = res_valid;
    end
    check("bp_valid_seen", saw, 1);
    hs = res_sum; hid = res_id; hc = res_carry;
    req0_valid = 1; req0_a = 32'hA; req0_b = 32'h3; req0_sub = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_sum", res_sum, hs);
      check("bp_hold_id_carry", {hid, hc}, {res_id, res_carry});
      check("bp_req0_ready", req0_ready, 0);
    end
    @(negedge clk);
    res_ready = 1;
    #1;
    check("bp_release_ready", req0_ready, 0);
    @(negedge clk);
    #1;
    check("bp_accept_next", req0_ready, 1);
    if (req0_ready) sb.push_back('{1'b0, 32'h7, 1'b1});
    @(posedge clk);
    #1;
    req0_valid = 0;
    drain();

    // Abort an op after two slices; nothing may come out and a fresh op must be clean.
    issue(0, 32'h0000FF00, 32'h00000100, 0, 0, 32'h0, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check("abort_res_valid", res_valid, 0);
    check("abort_res_sum", res_sum, 0);
    @(negedge clk);
    rst_n = 1;
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (res_valid) saw = 1;
    end
    check("abort_no_result", saw, 0);
    issue(1, 32'h000000FF, 32'h00000001, 0, 1, 32'h00000100, 0);
    drain();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule
